// File: rtl/pattern_sweep_pkg.sv
// pattern_sweep_pkg
// Shared definitions for the exhaustive pattern sweep controller:
//   sweep_state_t : controller states (IDLE, APPLY, EMIT, FINISH)
//   SIG_W         : width of the optional output signature
//   SIG_POLY      : CRC-16/CCITT feedback polynomial used by the signature MISR
package pattern_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        EMIT   = 2'd2,
        FINISH = 2'd3
    } sweep_state_t;

    localparam int SIG_W = 16;
    localparam logic [SIG_W-1:0] SIG_POLY = 16'h1021;

endpackage

// File: rtl/pattern_sweep_ctrl_signature.sv
// sweep_signature
// Multiple-input signature register that compresses every accepted result
// value into a 16-bit CRC-style signature.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset (signature -> 0)
//   clear  in   synchronous clear at the start of a sweep
//   enable in   shift in `data` this cycle
//   data   in   N_OUT result value, zero-extended into the signature
//   sig    out  current signature
module sweep_signature
    import pattern_sweep_pkg::*;
#(
    parameter int N_OUT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [N_OUT-1:0] data,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] data_ext;
    logic [SIG_W-1:0] feedback;

    assign data_ext = SIG_W'(data);
    assign feedback = sig[SIG_W-1] ? SIG_POLY : '0;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sig <= '0;
        end else if (enable) begin
            sig <= {sig[SIG_W-2:0], 1'b0} ^ feedback ^ data_ext;
        end
    end

endmodule

// File: rtl/pattern_sweep_ctrl.sv
// pattern_sweep_ctrl
// Cycle-accurate exhaustive stimulus sequencer. On `start` it walks dut_in
// through 0 .. 2^N_IN-1, holds each pattern for SETTLE cycles, captures
// dut_out and offers (pattern, value) to a sink over valid/ready.
//
// Handshake: a result transfers on a rising edge where res_valid && res_ready
// are both high. Once raised, res_valid and its payload stay stable until
// that transfer; only abort or reset withdraw it.
//
// Ports:
//   CK          in   clock, rising edge
//   reset       in   synchronous active-high reset
//   start       in   begin a sweep (IDLE only; wins over abort in IDLE)
//   abort       in   return to IDLE from any other state, no done pulse
//   dut_in      out  N_IN  pattern driven to the device under test
//   dut_out     in   N_OUT device response
//   res_valid   out  result pair available
//   res_ready   in   sink accepts the result
//   res_pattern out  N_IN  pattern that produced res_value
//   res_value   out  N_OUT captured response
//   busy        out  high in every state except IDLE
//   done        out  one-cycle pulse after the last result is accepted
//   fsm_state   out  current controller state, for debug/checkers
//   sig         out  16-bit result signature (only with
//                    PATTERN_SWEEP_SIGNATURE_EN defined)
//
// Build option: define PATTERN_SWEEP_SIGNATURE_EN to add the `sig` output
// and its MISR; without it the port and logic are absent.
module pattern_sweep_ctrl
    import pattern_sweep_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 1
) (
    input  logic              CK,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   dut_in,
    input  logic [N_OUT-1:0]  dut_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [N_IN-1:0]   res_pattern,
    output logic [N_OUT-1:0]  res_value,
    output logic              busy,
    output logic              done,
    output sweep_state_t      fsm_state
`ifdef PATTERN_SWEEP_SIGNATURE_EN
    ,
    output logic [SIG_W-1:0]  sig
`endif
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    sweep_state_t  state;
    logic [CW-1:0] cnt;

    assign fsm_state = state;

    always_ff @(posedge CK) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            dut_in      <= '0;
            res_valid   <= 1'b0;
            res_pattern <= '0;
            res_value   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) begin
                // abort outranks a same-cycle handshake and suppresses done
                state     <= IDLE;
                cnt       <= '0;
                res_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state  <= APPLY;
                            busy   <= 1'b1;
                            dut_in <= '0;
                            cnt    <= '0;
                        end
                    end
                    APPLY: begin
                        if (cnt == CNT_LAST) begin
                            res_value   <= dut_out;
                            res_pattern <= dut_in;
                            res_valid   <= 1'b1;
                            state       <= EMIT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    EMIT: begin
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            if (&dut_in) begin
                                // all-ones is the last pattern, so dut_in never wraps
                                state <= FINISH;
                                done  <= 1'b1;
                            end else begin
                                dut_in <= dut_in + 1'b1;
                                cnt    <= '0;
                                state  <= APPLY;
                            end
                        end
                    end
                    FINISH: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PATTERN_SWEEP_SIGNATURE_EN
    logic sig_clear;
    logic sig_enable;

    assign sig_clear  = (state == IDLE) && start;
    assign sig_enable = (state == EMIT) && res_valid && res_ready && !abort;

    sweep_signature #(
        .N_OUT (N_OUT)
    ) u_signature (
        .clk    (CK),
        .reset  (reset),
        .clear  (sig_clear),
        .enable (sig_enable),
        .data   (res_value),
        .sig    (sig)
    );
`endif

endmodule

// File: tb/tb_pattern_sweep_ctrl.sv
// tb_pattern_sweep_ctrl
// Bench for pattern_sweep_ctrl. Instance "a" (N_IN=3, SETTLE=1) drives an
// AND (or XOR) of its inputs; instance "b" (SETTLE=4) drives a two-stage
// registered inverter of dut_in[0]. Expected result pairs are queued when a
// sweep is launched and popped as each handshake occurs.
// With PATTERN_SWEEP_SIGNATURE_EN defined the `sig` outputs are also checked.
module tb_pattern_sweep_ctrl;
    import pattern_sweep_pkg::*;

    // ---------------- clock / reset ----------------
    logic CK = 1'b0;
    logic reset = 1'b1;
    always #5 CK = ~CK;

    // ---------------- instance a ----------------
    logic         start_a = 1'b0, abort_a = 1'b0, res_ready_a = 1'b1;
    logic [2:0]   dut_in_a, res_pattern_a;
    logic         dut_out_a, res_valid_a, res_value_a, busy_a, done_a;
    sweep_state_t state_a;
    logic         xor_mode = 1'b0;
    assign dut_out_a = xor_mode ? ^dut_in_a : &dut_in_a;

    // ---------------- instance b ----------------
    logic         start_b = 1'b0, abort_b = 1'b0, res_ready_b = 1'b1;
    logic [2:0]   dut_in_b, res_pattern_b;
    logic         dut_out_b, res_valid_b, res_value_b, busy_b, done_b;
    sweep_state_t state_b;
    logic         inv_r1, inv_r2;
    always @(posedge CK) begin
        inv_r1 <= ~dut_in_b[0];
        inv_r2 <= inv_r1;
    end
    assign dut_out_b = inv_r2;

`ifdef PATTERN_SWEEP_SIGNATURE_EN
    logic [15:0] sig_a, sig_b;
`endif

    pattern_sweep_ctrl #(.N_IN(3), .N_OUT(1), .SETTLE(1)) dut_a (
        .CK(CK), .reset(reset), .start(start_a), .abort(abort_a),
        .dut_in(dut_in_a), .dut_out(dut_out_a),
        .res_valid(res_valid_a), .res_ready(res_ready_a),
        .res_pattern(res_pattern_a), .res_value(res_value_a),
        .busy(busy_a), .done(done_a), .fsm_state(state_a)
`ifdef PATTERN_SWEEP_SIGNATURE_EN
        , .sig(sig_a)
`endif
    );

    pattern_sweep_ctrl #(.N_IN(3), .N_OUT(1), .SETTLE(4)) dut_b (
        .CK(CK), .reset(reset), .start(start_b), .abort(abort_b),
        .dut_in(dut_in_b), .dut_out(dut_out_b),
        .res_valid(res_valid_b), .res_ready(res_ready_b),
        .res_pattern(res_pattern_b), .res_value(res_value_b),
        .busy(busy_b), .done(done_b), .fsm_state(state_b)
`ifdef PATTERN_SWEEP_SIGNATURE_EN
        , .sig(sig_b)
`endif
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad = 0;
    logic [3:0] exp_q_a[$];
    logic [3:0] exp_q_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(negedge CK) begin : mon_a
        logic [3:0] e;
        if (!reset && res_valid_a && res_ready_a && !abort_a) begin
            if (exp_q_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_a_unexpected: got pattern %0d value %0d, required none",
                         res_pattern_a, res_value_a);
            end else begin
                e = exp_q_a.pop_front();
                check("sb_a_pair", {28'd0, res_pattern_a, res_value_a}, {28'd0, e});
            end
        end
    end

    always @(negedge CK) begin : mon_b
        logic [3:0] e;
        if (!reset && res_valid_b && res_ready_b && !abort_b) begin
            if (exp_q_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_b_unexpected: got pattern %0d value %0d, required none",
                         res_pattern_b, res_value_b);
            end else begin
                e = exp_q_b.pop_front();
                check("sb_b_pair", {28'd0, res_pattern_b, res_value_b}, {28'd0, e});
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0] pattern;
        logic       and_val;
        logic       xor_val;
        logic       inv_val;
    } vec_t;
    vec_t tbl[8];

    task automatic push_a(input int count);
        for (int i = 0; i < count; i++)
            exp_q_a.push_back({tbl[i].pattern, xor_mode ? tbl[i].xor_val : tbl[i].and_val});
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(output int n);
        n = 1;
        while (!done_a && n < 300) begin
            step();
            n++;
        end
    endtask

    task automatic wait_emit_a(input logic [2:0] p, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (res_valid_a && res_pattern_a == p) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_apply_a(input logic [2:0] p, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (state_a == APPLY && dut_in_a == p) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_dut_in"}, 32'(dut_in_a), 0);
        check({tag, "_res_valid"}, 32'(res_valid_a), 0);
        check({tag, "_res_pattern"}, 32'(res_pattern_a), 0);
        check({tag, "_res_value"}, 32'(res_value_a), 0);
        check({tag, "_busy"}, 32'(busy_a), 0);
        check({tag, "_done"}, 32'(done_a), 0);
        check({tag, "_state"}, 32'(state_a), 32'(IDLE));
    endtask

`ifdef PATTERN_SWEEP_SIGNATURE_EN
    function automatic logic [15:0] sig_model(input logic [15:0] s, input logic v);
        logic [15:0] nxt;
        nxt = {s[14:0], 1'b0};
        if (s[15]) nxt = nxt ^ 16'h1021;
        return nxt ^ {15'd0, v};
    endfunction
`endif

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int n;
        logic ok;
        logic seen_done;

        for (int i = 0; i < 8; i++) begin
            tbl[i].pattern = 3'(i);
            tbl[i].and_val = (i == 7);
            tbl[i].xor_val = ((i & 1) != 0) ^ ((i & 2) != 0) ^ ((i & 4) != 0);
            tbl[i].inv_val = ((i & 1) == 0);
        end

        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check_reset_a("rst");
        check("rst_b_busy", 32'(busy_b), 0);

        // full sweep, sink always ready
        push_a(8);
        pulse_start_a();
        check("start_busy", 32'(busy_a), 1);
        check("start_dut_in", 32'(dut_in_a), 0);
        check("start_no_valid_yet", 32'(res_valid_a), 0);
        wait_done_a(n);
        check("sweep_done_latency", 32'(n), 17);
        check("sweep_last_pattern", 32'(dut_in_a), 7);
        step();
        check("done_one_cycle", 32'(done_a), 0);
        check("idle_busy", 32'(busy_a), 0);
        check("idle_keeps_dut_in", 32'(dut_in_a), 7);
        check("sweep_queue_empty", 32'(exp_q_a.size()), 0);

        // sink stalls for 3 cycles on pattern 2
        push_a(8);
        pulse_start_a();
        wait_emit_a(3'd2, ok);
        check("stall_reach_p2", 32'(ok), 1);
        res_ready_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", 32'(res_valid_a), 1);
            check("stall_pattern", 32'(res_pattern_a), 2);
            check("stall_dut_in", 32'(dut_in_a), 2);
        end
        res_ready_a = 1'b1;
        wait_done_a(n);
        check("stall_done", 32'(done_a), 1);
        step();

        // abort while offering pattern 5 (same cycle as a ready handshake)
        push_a(5);
        pulse_start_a();
        wait_emit_a(3'd5, ok);
        check("abort_reach_p5", 32'(ok), 1);
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        check("abort_state", 32'(state_a), 32'(IDLE));
        check("abort_valid", 32'(res_valid_a), 0);
        check("abort_busy", 32'(busy_a), 0);
        seen_done = done_a;
        for (int i = 0; i < 5; i++) begin
            step();
            seen_done = seen_done | done_a;
        end
        check("abort_no_done", 32'(seen_done), 0);
        check("abort_queue_empty", 32'(exp_q_a.size()), 0);
        push_a(8);
        pulse_start_a();
        check("restart_dut_in", 32'(dut_in_a), 0);
        wait_done_a(n);
        check("restart_done_latency", 32'(n), 17);
        step();

        // reset during APPLY of pattern 3
        push_a(3);
        pulse_start_a();
        wait_apply_a(3'd3, ok);
        check("reset_reach_p3", 32'(ok), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_a("midrst");
        check("midrst_queue_empty", 32'(exp_q_a.size()), 0);
        push_a(8);
        pulse_start_a();
        wait_done_a(n);
        check("replay_done_latency", 32'(n), 17);
        step();

        // SETTLE=4 against a registered inverter
        for (int i = 0; i < 8; i++)
            exp_q_b.push_back({tbl[i].pattern, tbl[i].inv_val});
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        n = 1;
        while (!res_valid_b && n < 100) begin
            step();
            n++;
        end
        check("b_first_capture", 32'(n), 5);
        while (!done_b && n < 300) begin
            step();
            n++;
        end
        check("b_done_latency", 32'(n), 41);
        step();
        check("b_queue_empty", 32'(exp_q_b.size()), 0);

`ifdef PATTERN_SWEEP_SIGNATURE_EN
        begin : sig_test
            logic [15:0] ref_sig;
            ref_sig = 16'h0;
            for (int i = 0; i < 8; i++)
                ref_sig = sig_model(ref_sig, tbl[i].xor_val);
            xor_mode = 1'b1;
            for (int pass = 0; pass < 2; pass++) begin
                push_a(8);
                pulse_start_a();
                check("sig_cleared_on_start", 32'(sig_a), 0);
                wait_done_a(n);
                step();
                check("sig_after_sweep", 32'(sig_a), 32'(ref_sig));
                step();
                step();
                check("sig_holds_idle", 32'(sig_a), 32'(ref_sig));
            end
        end
`endif

        step();
        step();
        check("final_queue_a_empty", 32'(exp_q_a.size()), 0);
        check("final_queue_b_empty", 32'(exp_q_b.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pattern_sweep_ctrl.md
# pattern_sweep_ctrl

Exhaustive stimulus sequencer for the combinational/sequential benchmark cells in the trojan-detection flow. On `start` it drives every input pattern from 0 to 2^N_IN−1 into the device under test, waits a programmable settle time, captures the DUT output, and hands each (pattern, value) pair to a result sink over a valid/ready handshake. It replaces free-running `#delay` stimulus with a cycle-accurate controller that can sit in front of any benchmark instance, either in a bench or on an FPGA capture harness.

## Interface
- `N_IN`, 3, DUT input width; sweep covers 2^N_IN patterns; range 1–16.
- `N_OUT`, 1, DUT output width; range 1–16.
- `SETTLE`, 1, cycles each pattern is held before capture; minimum 1.

Ports:
- `CK`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- `abort`  in  1  terminate the sweep; honoured in any non-IDLE state.
- `dut_in`  out  N_IN  pattern driven to the DUT.
- `dut_out`  in  N_OUT  DUT response.
- `res_valid`  out  1  result pair available.
- `res_ready`  in  1  sink accepts the result.
- `res_pattern`  out  N_IN  pattern that produced `res_value`.
- `res_value`  out  N_OUT  captured DUT output.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last result is accepted.

## Operation
- States: IDLE, APPLY, EMIT, FINISH.
- IDLE: `start`=1 → APPLY. Set `dut_in`=0 and settle counter=0.
- APPLY: the settle counter increments every cycle. When the counter reaches SETTLE−1, sample `dut_out` into `res_value`, copy `dut_in` into `res_pattern`, set `res_valid`=1, and go to EMIT.
- EMIT: hold `res_valid`, `res_pattern`, `res_value`, and `dut_in` stable until `res_valid && res_ready`. Then:
  - if `dut_in` is all-ones, clear `res_valid` and go to FINISH;
  - otherwise increment `dut_in`, clear the counter and `res_valid`, and go to APPLY.
- FINISH: `done`=1 for exactly this cycle, then IDLE. `dut_in` keeps its last value.
- `abort` in APPLY, EMIT, or FINISH: go to IDLE next cycle with `res_valid`=0, counter=0, and no `done` pulse. `abort` has priority over the handshake in the same cycle.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE: start wins.
- Pattern increment is modulo 2^N_IN. Wrap never occurs because the all-ones pattern ends the sweep.

## Timing
- Reset values: state=IDLE, `dut_in`=0, `res_valid`=0, `res_pattern`=0, `res_value`=0, `busy`=0, `done`=0, counter=0.
- `reset` mid-sweep forces the reset values on the next edge. No result is emitted and no `done` pulse occurs.
- `start` at edge t puts the first pattern on `dut_in` after t. Capture happens at edge t+SETTLE, and `res_valid` is high from t+SETTLE.
- With `res_ready` tied high, each pattern costs SETTLE+1 cycles. A full sweep is 2^N_IN·(SETTLE+1)+1 cycles from `start` to `done`.
- `res_valid` is never withdrawn without a handshake, except on `abort` or reset.

## Configuration
- `PATTERN_SWEEP_SIGNATURE_EN` defined: adds output `sig` [15:0].
  - Cleared to 0 when a sweep starts.
  - Updated on every accepted result: sig ← {sig[14:0],0} ^ (sig[15] ? 16'h1021 : 0) ^ zero-extended `res_value`.
  - Holds its value after `done` until the next `start` or reset.
- `PATTERN_SWEEP_SIGNATURE_EN` undefined: no `sig` port and no signature logic. All other behaviour is identical.

## Structure
- Shared package `pattern_sweep_pkg`: state enum (IDLE, APPLY, EMIT, FINISH), CRC polynomial constant 16'h1021, and signature width 16.
- One natural sub-module, `sweep_signature`: the MISR register with clear and enable. It is instantiated only under the macro.

## Test plan
- N_IN=3, SETTLE=1, DUT = AND of all inputs, `res_ready`=1, pulse `start` → eight results with patterns 0…7 and values 0,0,0,0,0,0,0,1; `done` arrives 17 cycles after `start`.
- Same setup, `res_ready` low for 3 cycles during pattern 2 → `res_valid`, `res_pattern`=2, and `dut_in` stay stable for all 3 cycles; the sweep resumes with pattern 3.
- SETTLE=4, DUT is a 2-cycle registered inverter → every captured value equals the inverted pattern bit; no stale values appear.
- `abort` asserted while in EMIT for pattern 5 → next cycle IDLE and `res_valid`=0; `done` never pulses; a following `start` restarts at pattern 0.
- `reset` asserted during APPLY of pattern 3 → all outputs return to their reset values on the next edge; a new `start` replays the full sweep.
- With the macro defined, DUT = XOR of all inputs and a full sweep → `sig` matches a reference model fed 0,1,1,0,1,0,0,1; a second sweep produces the same `sig`.
